// File: rtl/button_debouncer_multi_if.sv
// button_debouncer_multi_if: bundles the pad inputs and the debounced outputs of
// button_debouncer_multi.
// Signalling: there is no valid/ready handshake. btn_in is an asynchronous level that
// is sampled freely. btn_level is a level. press_pulse, release_pulse and any_press
// are single-cycle strobes that are never high on two consecutive cycles.
interface button_debouncer_multi_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] btn_in;
    logic [NUM_CH-1:0] btn_level;
    logic [NUM_CH-1:0] press_pulse;
    logic [NUM_CH-1:0] release_pulse;
    logic              any_press;

    // Pad side / consumer side (testbench, game FSM wrapper)
    modport master (
        output btn_in,
        input  btn_level, press_pulse, release_pulse, any_press
    );

    // Debouncer side
    modport slave (
        input  btn_in,
        output btn_level, press_pulse, release_pulse, any_press
    );
endinterface

// File: rtl/button_debouncer_multi.sv
// button_debouncer_multi: N-channel button debouncer.
// Each channel has a 2-FF synchroniser, polarity correction and an integrating counter
// that advances on a shared sample tick. The outputs are a clean level plus one-cycle
// press and release pulses.
// Optional feature macro: DEBOUNCE_AUTOREPEAT_EN. When it is defined, press pulses
// re-fire while a button is held: the first repeat comes REPEAT_DELAY ticks after the
// press, and later repeats come every REPEAT_RATE ticks.
module button_debouncer_multi #(
    parameter int NUM_CH         = 4,
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter int ACTIVE_LOW     = 0,
    parameter int REPEAT_DELAY   = 100,
    parameter int REPEAT_RATE    = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    button_debouncer_multi_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    // Pad value of a released button; the synchroniser resets to it so that
    // leaving reset never looks like an edge.
    localparam logic [NUM_CH-1:0] IDLE_PAD = (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

    // Reject nonsensical configurations at elaboration time
    if (NUM_CH < 1 || TICK_DIV < 2 || STABLE_SAMPLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("button_debouncer_multi: illegal parameter value");
    end

    logic [PW-1:0]     presc;
    logic              tick;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] raw;
    logic [CW-1:0]     cnt [NUM_CH];
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] rel;
    logic              any;
    logic [NUM_CH-1:0] flip;
    logic [NUM_CH-1:0] rep_fire;
    logic [NUM_CH-1:0] press_nxt;
    logic [NUM_CH-1:0] rel_nxt;

    assign tick = (presc == PW'(TICK_DIV - 1));
    assign raw  = sync2 ^ IDLE_PAD;

    // Shared prescaler: wraps at TICK_DIV-1 and produces a one-clock sample tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous pads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= IDLE_PAD;
            sync2 <= IDLE_PAD;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    // A channel flips on the tick that completes STABLE_SAMPLES disagreeing samples
    always_comb begin
        flip = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            flip[i] = tick && (raw[i] != level[i]) && (cnt[i] == CW'(STABLE_SAMPLES - 1));
        end
    end

    assign press_nxt = (flip & raw) | rep_fire;
    assign rel_nxt   = flip & ~raw;

    // Integrating counters: any agreeing sample discards the partial count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (raw[i] == level[i] || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounced level and registered event pulses; the pulse appears together with the new level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            press <= '0;
            rel   <= '0;
            any   <= 1'b0;
        end else begin
            level <= level ^ flip;
            press <= press_nxt;
            rel   <= rel_nxt;
            any   <= |press_nxt;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    // rtmr counts ticks since the last press or repeat; rpt_armed marks that the first
    // repeat has fired, so the shorter REPEAT_RATE interval applies from then on.
    logic [RW-1:0]     rtmr [NUM_CH];
    logic [NUM_CH-1:0] rpt_armed;

    // Repeat fires on the tick where the held-time counter reaches its current interval
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rep_fire[i] = tick && level[i] && !flip[i] &&
                          ((rtmr[i] + RW'(1)) == (rpt_armed[i] ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY)));
        end
    end

    // Repeat timers: idle while released and cleared on every level change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rtmr[i] <= '0;
            end
            rpt_armed <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!level[i] || flip[i]) begin
                    rtmr[i]      <= '0;
                    rpt_armed[i] <= 1'b0;
                end else if (tick) begin
                    if (rep_fire[i]) begin
                        rtmr[i]      <= '0;
                        rpt_armed[i] <= 1'b1;
                    end else begin
                        rtmr[i] <= rtmr[i] + RW'(1);
                    end
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign bus.btn_level     = level;
    assign bus.press_pulse   = press;
    assign bus.release_pulse = rel;
    assign bus.any_press     = any;
endmodule

// File: tb/tb_button_debouncer_multi.sv
// tb_button_debouncer_multi: drives two debouncer instances, one with active-high pads
// and one with active-low pads. A sample-window reference model predicts every output
// on every cycle, and directed scenarios pin the timing with literal expectations.
module tb_button_debouncer_multi;
    localparam int NUM_CH   = 2;
    localparam int TICK_DIV = 4;
    localparam int SS       = 3;
    localparam int RD       = 8;
    localparam int RR       = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    button_debouncer_multi_if #(.NUM_CH(NUM_CH)) bus_a ();
    button_debouncer_multi_if #(.NUM_CH(NUM_CH)) bus_b ();

    button_debouncer_multi #(
        .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .STABLE_SAMPLES(SS),
        .ACTIVE_LOW(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    button_debouncer_multi #(
        .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .STABLE_SAMPLES(SS),
        .ACTIVE_LOW(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model keeps the last SS tick samples of each channel. A level changes when
    // all of those samples show the opposite value. After a change the window is
    // refilled with the new value, so the next change again needs SS fresh samples.
    logic [NUM_CH-1:0] m_hist1 [2];
    logic [NUM_CH-1:0] m_hist2 [2];
    bit                m_win   [2][NUM_CH][SS];
    logic [NUM_CH-1:0] m_level [2];
    logic [NUM_CH-1:0] m_press [2];
    logic [NUM_CH-1:0] m_rel   [2];
    logic              m_any   [2];
    int                m_held  [2][NUM_CH];
    int unsigned       m_k;

    function automatic logic [NUM_CH-1:0] idle_pad(input int p);
        return (p == 1) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
    endfunction

    function automatic logic [NUM_CH-1:0] pad(input int p);
        return (p == 1) ? bus_b.btn_in : bus_a.btn_in;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_k = 0;
                for (int p = 0; p < 2; p++) begin
                    m_hist1[p] = idle_pad(p);
                    m_hist2[p] = idle_pad(p);
                    m_level[p] = '0;
                    m_press[p] = '0;
                    m_rel[p]   = '0;
                    m_any[p]   = 1'b0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        m_held[p][c] = 0;
                        for (int j = 0; j < SS; j++) m_win[p][c][j] = 1'b0;
                    end
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    logic [NUM_CH-1:0] raw;
                    raw = m_hist2[p] ^ idle_pad(p);
                    m_hist2[p] = m_hist1[p];
                    m_hist1[p] = pad(p);
                    m_press[p] = '0;
                    m_rel[p]   = '0;
                    if ((m_k % TICK_DIV) == TICK_DIV - 1) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            bit opposite;
                            for (int j = SS - 1; j > 0; j--) m_win[p][c][j] = m_win[p][c][j-1];
                            m_win[p][c][0] = raw[c];
                            opposite = 1'b1;
                            for (int j = 0; j < SS; j++) begin
                                if (m_win[p][c][j] == m_level[p][c]) opposite = 1'b0;
                            end
                            if (opposite) begin
                                m_level[p][c] = raw[c];
                                for (int j = 0; j < SS; j++) m_win[p][c][j] = raw[c];
                                if (raw[c]) m_press[p][c] = 1'b1;
                                else        m_rel[p][c]   = 1'b1;
                                m_held[p][c] = 0;
                            end
`ifdef DEBOUNCE_AUTOREPEAT_EN
                            else if (m_level[p][c]) begin
                                m_held[p][c]++;
                                if (m_held[p][c] == RD ||
                                    (m_held[p][c] > RD && ((m_held[p][c] - RD) % RR) == 0))
                                    m_press[p][c] = 1'b1;
                            end
`endif
                        end
                    end
                    m_any[p] = |m_press[p];
                end
                m_k++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("level_a",   bus_a.btn_level,     m_level[0]);
            check("press_a",   bus_a.press_pulse,   m_press[0]);
            check("release_a", bus_a.release_pulse, m_rel[0]);
            check("any_a",     bus_a.any_press,     m_any[0]);
            check("level_b",   bus_b.btn_level,     m_level[1]);
            check("press_b",   bus_b.press_pulse,   m_press[1]);
            check("release_b", bus_b.release_pulse, m_rel[1]);
            check("any_b",     bus_b.any_press,     m_any[1]);
        end
    end

    // ---------------- driver tasks / event counters ----------------
    int cnt_press [2][NUM_CH];
    int cnt_rel   [2][NUM_CH];
    int b_total = 0;
    int cyc_no  = 0;
    int pt [$];

    task automatic step();
        @(negedge clk);
        cyc_no++;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_press[0][c] += int'(bus_a.press_pulse[c]);
            cnt_rel[0][c]   += int'(bus_a.release_pulse[c]);
            cnt_press[1][c] += int'(bus_b.press_pulse[c]);
            cnt_rel[1][c]   += int'(bus_b.release_pulse[c]);
            b_total += int'(bus_b.press_pulse[c]) + int'(bus_b.release_pulse[c]);
        end
        if (bus_a.press_pulse[0]) pt.push_back(cyc_no);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_press[p][c] = 0;
                cnt_rel[p][c]   = 0;
            end
        end
        pt.delete();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        bit found;
        int start;
        int first;
        int gap1;
        int gap2;
        bit seen_rel;
        int post;

        bus_a.btn_in = 2'b11;
        bus_b.btn_in = 2'b11;
        clear_counts();

        // 1: reset held 3 clocks with both pads pressed
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_level_a", bus_a.btn_level, 0);
            check("rst_press_a", bus_a.press_pulse, 0);
            check("rst_rel_a",   bus_a.release_pulse, 0);
            check("rst_any_a",   bus_a.any_press, 0);
            check("rst_level_b", bus_b.btn_level, 0);
        end
        rst = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            n++;
            if (bus_a.press_pulse != 0) found = 1'b1;
        end
        check("t1_latency", n, 12);
        check("t1_press_both", bus_a.press_pulse, 2'b11);
        check("t1_any_press", bus_a.any_press, 1);
        step();
        check("t1_press_clear", bus_a.press_pulse, 0);
        check("t1_any_clear", bus_a.any_press, 0);

        bus_a.btn_in = 2'b00;
        clear_counts();
        steps(30);
        check("t1_rel_ch0", cnt_rel[0][0], 1);
        check("t1_rel_ch1", cnt_rel[0][1], 1);

        // 2: clean press on ch0
        clear_counts();
        start = cyc_no;
        bus_a.btn_in[0] = 1'b1;
        steps(40);
        first = (pt.size() > 0) ? pt[0] - start : 0;
        check("t2_latency_le_15", (first >= 1 && first <= 15), 1);
        check("t2_press_count", cnt_press[0][0], 1);
        check("t2_ch1_quiet", cnt_press[0][1] + cnt_rel[0][1], 0);
        check("t2_level", bus_a.btn_level, 2'b01);

        // 3: bounce every 3 clocks, then settle pressed
        bus_a.btn_in[0] = 1'b0;
        steps(30);
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            bus_a.btn_in[0] = ~bus_a.btn_in[0];
            steps(3);
        end
        check("t3_bounce_press", cnt_press[0][0], 0);
        check("t3_bounce_rel", cnt_rel[0][0], 0);
        bus_a.btn_in[0] = 1'b1;
        clear_counts();
        steps(20);
        check("t3_settle_press", cnt_press[0][0], 1);
        check("t3_settle_level", bus_a.btn_level[0], 1);

        // 4: one-tick dropout is rejected, long dropout releases
        clear_counts();
        bus_a.btn_in[0] = 1'b0;
        steps(4);
        bus_a.btn_in[0] = 1'b1;
        steps(20);
        check("t4_glitch_rel", cnt_rel[0][0], 0);
        check("t4_glitch_level", bus_a.btn_level[0], 1);
        clear_counts();
        bus_a.btn_in[0] = 1'b0;
        steps(20);
        check("t4_rel_count", cnt_rel[0][0], 1);
        check("t4_rel_level", bus_a.btn_level[0], 0);

        // 5: active-low instance
        check("t5_idle_quiet", b_total, 0);
        clear_counts();
        bus_b.btn_in = 2'b01;
        steps(20);
        check("t5_press_ch1", cnt_press[1][1], 1);
        check("t5_quiet_ch0", cnt_press[1][0], 0);
        check("t5_level", bus_b.btn_level, 2'b10);
        bus_b.btn_in = 2'b11;
        clear_counts();
        steps(20);
        check("t5_rel_ch1", cnt_rel[1][1], 1);

        // 6: long hold on ch0 (auto-repeat when enabled)
        bus_a.btn_in = 2'b00;
        steps(10);
        clear_counts();
        bus_a.btn_in[0] = 1'b1;
        steps(120);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        gap1 = (pt.size() >= 2) ? pt[1] - pt[0] : -1;
        gap2 = (pt.size() >= 3) ? pt[2] - pt[1] : -1;
        check("t6_press_count", pt.size(), 6);
        check("t6_first_gap", gap1, RD * TICK_DIV);
        check("t6_second_gap", gap2, RR * TICK_DIV);
`else
        gap1 = 0;
        gap2 = 0;
        check("t6_single_press", pt.size(), 1);
`endif
        bus_a.btn_in[0] = 1'b0;
        clear_counts();
        seen_rel = 1'b0;
        post = gap1 - gap1 + gap2 - gap2;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_a.release_pulse[0]) seen_rel = 1'b1;
            else if (seen_rel && bus_a.press_pulse[0]) post++;
        end
        check("t6_rel_count", cnt_rel[0][0], 1);
        check("t6_no_press_after_rel", post, 0);

        // random pads with occasional resets; the per-cycle compare checks everything
        for (int it = 0; it < 700; it++) begin
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                steps($urandom_range(1, 3));
                rst = 1'b0;
            end
            bus_a.btn_in = NUM_CH'($urandom_range(0, 3));
            bus_b.btn_in = NUM_CH'($urandom_range(0, 3));
            steps($urandom_range(1, 30));
        end
        steps(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
